muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit fed by register-file read data (RD1/RD2) in EX stage.
//  Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles; pipeline stalls on busy.
//  Result returns to the register-file write port (WD/A3/RFWr) via the writeback mux.
// PARAMETERS
//  XLEN   32  operand/result width; only 32 supported
//  CNT_W  6   iteration counter width; holds 0..XLEN
// PORTS
//  clk     in   1     clock, rising edge
//  rstn    in   1     reset, asynchronous, active-low
//  start   in   1     request; sampled only when accepting (IDLE or DONE)
//  op      in   3     funct3 encoding, see package
//  a       in   32    rs1 value (RD1)
//  b       in   32    rs2 value (RD2)
//  rd_in   in   5     destination register
//  flush   in   1     abort current operation
//  busy    out  1     1 in CALC/FIN
//  done    out  1     one-cycle pulse in DONE state
//  result  out  32    final value; held until next accepted start
//  rd_out  out  5     destination register captured at start
//  rf_we   out  1     done & (rd_out != 0); drives RFWr
// BEHAVIOUR
//  Reset values: state IDLE, busy 0, done 0, result 0, rd_out 0, rf_we 0, counter 0.
//  States: IDLE -start-> CALC (normal) or DONE (special case); CALC -32 iters-> FIN -> DONE;
//   DONE -> IDLE, or CALC/DONE if start is high in DONE (back-to-back allowed).
//  Accept edge N: latch a, b, op, rd_in. Later input changes ignored. Start while busy ignored.
//  Timing: one iteration per edge N+1..N+32; FIN at N+33 (sign fix, result reg load);
//   done=1 from N+33 to N+34. Special cases: result loaded at N, done=1 from N to N+1.
//  MUL*: shift-add on magnitudes, 64-bit product.
//   Signedness: MULH a,b signed; MULHSU a signed, b unsigned; MULHU/MUL unsigned magnitudes.
//   Negate the 64-bit product in FIN if sign differs. MUL returns low 32 bits; MULH* return high 32.
//  DIV*: restoring division on magnitudes. Quotient negated if sa^sb; remainder takes sign of a.
//  Special cases, 1-cycle path:
//   - b==0: quotient 0xFFFFFFFF, remainder = a (DIV/DIVU/REM/REMU).
//   - DIV/REM with a==0x80000000, b==0xFFFFFFFF: quotient 0x80000000, remainder 0.
//  flush: any state -> IDLE next edge. No done, no rf_we. result/rd_out keep old values.
//   flush and start in the same cycle: flush wins, start dropped.
//  rstn low mid-operation: immediate return to reset values. No done pulse.
//  Arithmetic is modulo 2^32 / 2^64; no overflow flags.
// STRUCTURE
//  Package muldiv_pkg:
//   - op localparams: MUL=3'b000, MULH=001, MULHSU=010, MULHU=011,
//     DIV=100, DIVU=101, REM=110, REMU=111
//   - state encoding: IDLE, CALC, FIN, DONE
//   - XLEN constant
//  Single module, one FSM plus one datapath block: 64-bit acc/remainder reg, 32-bit operand reg, counter.
//  No sub-module.
// TESTING
//  1 MUL a=7, b=0xFFFFFFFD, rd=5, start at edge N -> busy 1..N+32, done at N+33,
//    result 0xFFFFFFEB, rd_out 5, rf_we 1.
//  2 MULH 0x80000000*0x80000000 -> 0x40000000.
//    MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//    MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
//  3 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  4 DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000, REM same -> 0;
//    each with done 1 cycle after start edge.
//  5 flush at N+10 -> busy 0 at N+11, no done. Second start at N+5 ignored.
//    rd=0 -> done 1, rf_we 0.
//  6 rstn low at N+15 -> all outputs 0 immediately. Back-to-back start in DONE accepted,
//    next done 33 cycles later.

Source files
------------

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared definitions for the iterative RV32M multiply/divide
//               unit: operand width, funct3 operation codes, FSM state
//               encoding and operand-signedness helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  localparam int XLEN = 32;

  // funct3 encodings of the M extension
  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // rs1 is treated as two's complement for MULH, MULHSU, DIV and REM
  function automatic logic a_is_signed(input logic [2:0] op);
    return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
  endfunction

  // rs2 is treated as two's complement for MULH, DIV and REM
  function automatic logic b_is_signed(input logic [2:0] op);
    return (op == MULH) || (op == DIV) || (op == REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit. Operands are converted
//               to magnitudes at accept time, processed one bit per cycle
//               (shift-add multiply / restoring divide) for 32 cycles, then
//               sign-corrected and loaded into the result register. Division
//               by zero and signed overflow bypass the iteration and finish
//               on the accepting edge.
// Ports       : clk, rstn (async, active-low)
//               start, op[2:0], a, b, rd_in, flush      - request side
//               busy, done, result, rd_out, rf_we       - status / writeback
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = muldiv_pkg::XLEN,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            rf_we
);

  localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  c_ones      = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  c_int_min   = {1'b1, {(XLEN-1){1'b0}}};

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0] r_acc;    // product {hi,lo} or {remainder, dividend/quotient}
  logic [XLEN-1:0]   r_opnd;   // multiplicand or divisor magnitude
  logic [2:0]        r_op;
  logic              r_neg_q;  // negate product / quotient in FIN
  logic              r_neg_r;  // negate remainder in FIN

  // ---------------------------------------------------------------- accept
  logic            w_accept;
  logic            w_is_div;
  logic            w_sa;
  logic            w_sb;
  logic [XLEN-1:0] w_amag;
  logic [XLEN-1:0] w_bmag;
  logic            w_div0;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;

  assign w_accept = start && !flush && ((r_state == IDLE) || (r_state == DONE));
  assign w_is_div = op[2];
  assign w_sa     = a_is_signed(op) && a[XLEN-1];
  assign w_sb     = b_is_signed(op) && b[XLEN-1];
  assign w_amag   = w_sa ? (~a + 1'b1) : a;
  assign w_bmag   = w_sb ? (~b + 1'b1) : b;
  assign w_div0   = w_is_div && (b == '0);
  assign w_ovf    = ((op == DIV) || (op == REM)) && (a == c_int_min) && (b == c_ones);
  assign w_special = w_div0 || w_ovf;

  // op[1] distinguishes REM/REMU from DIV/DIVU
  always_comb begin
    w_special_res = '0;
    if (w_div0) begin
      w_special_res = op[1] ? a : c_ones;
    end else if (w_ovf) begin
      w_special_res = op[1] ? '0 : c_int_min;
    end
  end

  // ------------------------------------------------------- one iteration
  // Multiply: add multiplicand into the high half when the low bit of the
  // multiplier is set, then shift the whole 65-bit value right by one.
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;

  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                      (r_acc[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Restoring divide: the shifted partial remainder can need 33 bits, but
  // after a successful subtract it always fits back into 32.
  logic [XLEN:0]     w_rem_sh;
  logic              w_fits;
  logic [XLEN-1:0]   w_rem_sub;
  logic [2*XLEN-1:0] w_div_next;

  assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
  assign w_fits     = w_rem_sh >= {1'b0, r_opnd};
  assign w_rem_sub  = w_rem_sh[XLEN-1:0] - r_opnd;
  assign w_div_next = w_fits ? {w_rem_sub,           r_acc[XLEN-2:0], 1'b1}
                             : {w_rem_sh[XLEN-1:0],  r_acc[XLEN-2:0], 1'b0};

  // ------------------------------------------------------- final fix-up
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fin_res;

  assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
  assign w_quot = r_neg_q ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
  assign w_rem  = r_neg_r ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fin_res = '0;
    case (r_op)
      MUL:                 w_fin_res = w_prod[XLEN-1:0];
      MULH, MULHSU, MULHU: w_fin_res = w_prod[2*XLEN-1:XLEN];
      DIV, DIVU:           w_fin_res = w_quot;
      default:             w_fin_res = w_rem;
    endcase
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      rd_out  <= '0;
      rf_we   <= 1'b0;
    end else if (flush) begin
      // abort without completion; result/rd_out keep their values
      r_state <= IDLE;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rf_we   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          done  <= 1'b0;
          rf_we <= 1'b0;
          busy  <= 1'b0;
          if (w_accept) begin
            rd_out <= rd_in;
            if (w_special) begin
              result  <= w_special_res;
              done    <= 1'b1;
              rf_we   <= (rd_in != '0);
              r_state <= DONE;
            end else begin
              busy    <= 1'b1;
              r_cnt   <= '0;
              r_state <= CALC;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last_iter) begin
            r_state <= FIN;
          end
        end
        FIN: begin
          result  <= w_fin_res;
          done    <= 1'b1;
          rf_we   <= (rd_out != '0);
          busy    <= 1'b0;
          r_cnt   <= '0;
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc   <= '0;
      r_opnd  <= '0;
      r_op    <= MUL;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_op    <= op;
      r_neg_q <= w_sa ^ w_sb;
      r_neg_r <= w_sa;
      if (w_is_div) begin
        r_acc  <= {{XLEN{1'b0}}, w_amag};
        r_opnd <= w_bmag;
      end else begin
        r_acc  <= {{XLEN{1'b0}}, w_bmag};
        r_opnd <= w_amag;
      end
    end else if ((r_state == CALC) && !flush) begin
      r_acc <= r_op[2] ? w_div_next : w_mul_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit. Each task
//               covers one feature and compares DUT outputs against
//               hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  rd_in;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        rf_we;

  int checks   = 0;
  int failures = 0;

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .rd_in  (rd_in),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out),
    .rf_we  (rf_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Issues one request at the next accept edge N and waits (bounded) for
  // done. lat = number of edges after N at which done is first seen.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] r, output int lat, output bit busy_ok);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; rd_in = r;
    @(negedge clk);
    start = 1'b0; op = ~o; a = $urandom; b = $urandom; rd_in = 5'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 60) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; flush = 1'b0; op = MUL; a = '0; b = '0; rd_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, result, rd_out, rf_we} !== 39'd0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b result=%h rd_out=%0d rf_we=%b expected all 0",
               busy, done, result, rd_out, rf_we);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    int lat; bit bok;
    run_op(MUL, 32'd7, 32'hFFFFFFFD, 5'd5, lat, bok);
    checks++;
    if (lat !== 33) begin failures++; $display("FAIL mul_latency got %0d expected 33", lat); end
    checks++;
    if (bok !== 1'b1) begin failures++; $display("FAIL mul_busy got busy low before done expected busy high"); end
    checks++;
    if (result !== 32'hFFFFFFEB) begin failures++; $display("FAIL mul_result got %h expected ffffffeb", result); end
    checks++;
    if ({rd_out, rf_we, busy} !== {5'd5, 1'b1, 1'b0}) begin
      failures++; $display("FAIL mul_wb got rd_out=%0d rf_we=%b busy=%b expected 5 1 0", rd_out, rf_we, busy);
    end
    @(negedge clk);
    checks++;
    if ({done, rf_we} !== 2'b00) begin failures++; $display("FAIL mul_done_pulse got done=%b rf_we=%b expected 0 0", done, rf_we); end
    run_op(MUL, 32'h12345678, 32'h10, 5'd1, lat, bok);
    checks++;
    if (result !== 32'h23456780) begin failures++; $display("FAIL mul_small got %h expected 23456780", result); end
  endtask

  task automatic test_mulh();
    int lat; bit bok;
    run_op(MULH, 32'h80000000, 32'h80000000, 5'd2, lat, bok);
    checks++;
    if (result !== 32'h40000000) begin failures++; $display("FAIL mulh got %h expected 40000000", result); end
    run_op(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, lat, bok);
    checks++;
    if (result !== 32'hFFFFFFFE) begin failures++; $display("FAIL mulhu got %h expected fffffffe", result); end
    run_op(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, lat, bok);
    checks++;
    if (result !== 32'hFFFFFFFF) begin failures++; $display("FAIL mulhsu got %h expected ffffffff", result); end
    checks++;
    if (lat !== 33) begin failures++; $display("FAIL mulhsu_latency got %0d expected 33", lat); end
  endtask

  task automatic test_div();
    int lat; bit bok;
    run_op(DIV, 32'hFFFFFFF9, 32'd2, 5'd7, lat, bok);
    checks++;
    if (result !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_neg got %h expected fffffffd", result); end
    checks++;
    if (lat !== 33) begin failures++; $display("FAIL div_latency got %0d expected 33", lat); end
    run_op(REM, 32'hFFFFFFF9, 32'd2, 5'd7, lat, bok);
    checks++;
    if (result !== 32'hFFFFFFFF) begin failures++; $display("FAIL rem_neg got %h expected ffffffff", result); end
    run_op(DIVU, 32'd100, 32'd7, 5'd7, lat, bok);
    checks++;
    if (result !== 32'd14) begin failures++; $display("FAIL divu got %h expected 0000000e", result); end
    run_op(REMU, 32'd100, 32'd7, 5'd7, lat, bok);
    checks++;
    if (result !== 32'd2) begin failures++; $display("FAIL remu got %h expected 00000002", result); end
    run_op(DIVU, 32'hFFFFFFFF, 32'd1, 5'd7, lat, bok);
    checks++;
    if (result !== 32'hFFFFFFFF) begin failures++; $display("FAIL divu_max got %h expected ffffffff", result); end
    run_op(REM, 32'd7, 32'hFFFFFFFE, 5'd7, lat, bok);
    checks++;
    if (result !== 32'd1) begin failures++; $display("FAIL rem_pos_neg got %h expected 00000001", result); end
  endtask

  task automatic test_special();
    int lat; bit bok;
    run_op(DIVU, 32'd5, 32'd0, 5'd8, lat, bok);
    checks++;
    if ({lat == 0, result, rf_we} !== {1'b1, 32'hFFFFFFFF, 1'b1}) begin
      failures++; $display("FAIL divu_by0 got lat=%0d result=%h rf_we=%b expected 0 ffffffff 1", lat, result, rf_we);
    end
    run_op(REM, 32'd5, 32'd0, 5'd8, lat, bok);
    checks++;
    if ({lat == 0, result} !== {1'b1, 32'd5}) begin
      failures++; $display("FAIL rem_by0 got lat=%0d result=%h expected 0 00000005", lat, result);
    end
    run_op(DIV, 32'h80000000, 32'hFFFFFFFF, 5'd8, lat, bok);
    checks++;
    if ({lat == 0, result} !== {1'b1, 32'h80000000}) begin
      failures++; $display("FAIL div_ovf got lat=%0d result=%h expected 0 80000000", lat, result);
    end
    run_op(REM, 32'h80000000, 32'hFFFFFFFF, 5'd8, lat, bok);
    checks++;
    if ({lat == 0, result} !== {1'b1, 32'd0}) begin
      failures++; $display("FAIL rem_ovf got lat=%0d result=%h expected 0 00000000", lat, result);
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin failures++; $display("FAIL special_pulse got done=%b busy=%b expected 0 0", done, busy); end
  endtask

  task automatic test_flush();
    int lat; bit bok; bit saw_done;
    // start while busy is ignored
    @(negedge clk);
    start = 1'b1; op = MUL; a = 32'd3; b = 32'd5; rd_in = 5'd3;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = DIVU; a = 32'd9; b = 32'd0; rd_in = 5'd9;
    @(negedge clk); start = 1'b0;
    lat = 5;
    while (!done && lat < 60) begin @(negedge clk); lat++; end
    checks++;
    if ({lat == 33, result, rd_out} !== {1'b1, 32'd15, 5'd3}) begin
      failures++; $display("FAIL start_while_busy got lat=%0d result=%h rd_out=%0d expected 33 0000000f 3", lat, result, rd_out);
    end
    // flush mid-operation
    @(negedge clk);
    start = 1'b1; op = MUL; a = 32'd4; b = 32'd4; rd_in = 5'd6;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin failures++; $display("FAIL flush_busy got busy=%b done=%b expected 0 0", busy, done); end
    saw_done = 1'b0;
    repeat (40) begin
      if (done || rf_we) saw_done = 1'b1;
      @(negedge clk);
    end
    checks++;
    if ({saw_done, result} !== {1'b0, 32'd15}) begin
      failures++; $display("FAIL flush_no_done got saw_done=%b result=%h expected 0 0000000f", saw_done, result);
    end
    // flush and start together: start dropped
    start = 1'b1; flush = 1'b1; op = DIVU; a = 32'd1; b = 32'd0; rd_in = 5'd4;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00) begin failures++; $display("FAIL flush_start got busy=%b done=%b expected 0 0", busy, done); end
    // rd 0: done without register write
    run_op(DIVU, 32'd100, 32'd7, 5'd0, lat, bok);
    checks++;
    if ({done, rf_we, result} !== {1'b1, 1'b0, 32'd14}) begin
      failures++; $display("FAIL rd0_no_write got done=%b rf_we=%b result=%h expected 1 0 0000000e", done, rf_we, result);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    @(negedge clk);
    start = 1'b1; op = MUL; a = 32'd7; b = 32'd3; rd_in = 5'd11;
    @(negedge clk); start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({busy, done, result, rd_out, rf_we} !== 39'd0) begin
      failures++;
      $display("FAIL reset_mid got busy=%b done=%b result=%h rd_out=%0d rf_we=%b expected all 0",
               busy, done, result, rd_out, rf_we);
    end
    @(negedge clk); rstn = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      if (done || busy) saw_done = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw_done !== 1'b0) begin failures++; $display("FAIL reset_mid_quiet got activity=%b expected 0", saw_done); end
  endtask

  task automatic test_back_to_back();
    int lat; bit bok;
    run_op(MUL, 32'd6, 32'd7, 5'd1, lat, bok);
    // now in DONE with done high: issue the next request immediately
    start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7; rd_in = 5'd4;
    @(negedge clk); start = 1'b0;
    checks++;
    if ({done, busy} !== 2'b01) begin failures++; $display("FAIL b2b_accept got done=%b busy=%b expected 0 1", done, busy); end
    lat = 0;
    while (!done && lat < 60) begin @(negedge clk); lat++; end
    checks++;
    if ({lat == 33, result, rd_out} !== {1'b1, 32'd14, 5'd4}) begin
      failures++; $display("FAIL b2b_second got lat=%0d result=%h rd_out=%0d expected 33 0000000e 4", lat, result, rd_out);
    end
    // special case straight out of DONE
    start = 1'b1; op = DIVU; a = 32'd3; b = 32'd0; rd_in = 5'd2;
    @(negedge clk); start = 1'b0;
    checks++;
    if ({done, result, rd_out} !== {1'b1, 32'hFFFFFFFF, 5'd2}) begin
      failures++; $display("FAIL b2b_special got done=%b result=%h rd_out=%0d expected 1 ffffffff 2", done, result, rd_out);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
